// File: rtl/mult4_product_accumulator_pkg.sv
// Shared definitions for the product accumulator and the multiplier stage
// that feeds it: FSM state type and default widths.
package mult4_product_accumulator_pkg;

    // Width of the unsigned product delivered by the 4x4 multiplier array.
    localparam int PRODUCT_W = 8;

    // Default accumulator and term-counter widths.
    localparam int ACC_W_DEFAULT = 12;
    localparam int CNT_W_DEFAULT = 5;

    // ACCUM: summing a packet; HOLD: presenting a finished packet result.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/black_cell.sv
// Prefix-tree black cell: merges two (generate, propagate) spans into one.
module black_cell (
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    input  logic p_lo_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = g_hi_i | (p_hi_i & g_lo_i);
    assign p_o = p_hi_i & p_lo_i;

endmodule

// File: rtl/gray_cell.sv
// Prefix-tree gray cell: merges a span with a lower span that already reaches
// bit 0, so only the group generate (the carry) is produced.
module gray_cell (
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    output logic g_o
);

    assign g_o = g_hi_i | (p_hi_i & g_lo_i);

endmodule

// File: rtl/mult4_acc_adder.sv
// W-bit Kogge-Stone prefix adder (no carry-in) producing sum and carry-out.
// Level k combines spans 2^(k-1) apart; a gray cell is used where the lower
// span already reaches bit 0, a black cell elsewhere. Propagate terms are
// kept only for bits whose prefix is still incomplete after a level.
module mult4_acc_adder #(
    parameter int W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    localparam int LEVELS = $clog2(W);

    logic [W-1:0] prop;
    logic [W-1:0] carry;

    assign prop = a_i ^ b_i;

    genvar k, i;
    for (k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int D   = (k == 0) ? 0 : (1 << (k - 1));
        localparam int PLO = 1 << k;

        logic [W-1:0] g_l;

        // Propagate is only needed for bits still incomplete after this level.
        if (PLO < W) begin : g_p
            logic [W-1:PLO] p_l;
        end

        if (k == 0) begin : g_init
            assign g_l     = a_i & b_i;
            assign g_p.p_l = prop[W-1:1];
        end else begin : g_step
            for (i = 0; i < W; i++) begin : g_bit
                if (i < D) begin : g_pass
                    assign g_l[i] = g_lvl[k-1].g_l[i];
                end else if (i < 2 * D) begin : g_gray
                    gray_cell u_gray (
                        .g_hi_i (g_lvl[k-1].g_l[i]),
                        .p_hi_i (g_lvl[k-1].g_p.p_l[i]),
                        .g_lo_i (g_lvl[k-1].g_l[i-D]),
                        .g_o    (g_l[i])
                    );
                end else begin : g_black
                    black_cell u_black (
                        .g_hi_i (g_lvl[k-1].g_l[i]),
                        .p_hi_i (g_lvl[k-1].g_p.p_l[i]),
                        .g_lo_i (g_lvl[k-1].g_l[i-D]),
                        .p_lo_i (g_lvl[k-1].g_p.p_l[i-D]),
                        .g_o    (g_l[i]),
                        .p_o    (g_p.p_l[i])
                    );
                end
            end
        end
    end

    // After the last level every bit holds the carry out of bits [i:0].
    assign carry  = g_lvl[LEVELS].g_l;
    assign sum_o  = prop ^ {carry[W-2:0], 1'b0};
    assign cout_o = carry[W-1];

endmodule

// File: rtl/mult4_product_accumulator.sv
// Packet accumulator for the 4x4 multiplier's 8-bit products. Sums products
// between in_last markers, counts terms (saturating) and flags any carry out
// of the accumulator, then holds the result on a valid/ready output port.
// Optional build macro ACC_SATURATE_EN: clamp the sum to all-ones once the
// packet has overflowed instead of wrapping.
module mult4_product_accumulator
    import mult4_product_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRODUCT_W-1:0] in_product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_cout;
    logic [ACC_W-1:0]   beat_acc;
    logic [CNT_W-1:0]   beat_cnt;
    logic               beat_ovf;

    // Running sum plus the zero-extended product; carry-out is the overflow.
    mult4_acc_adder #(
        .W (ACC_W)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (ACC_W'(in_product)),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Accumulator values that result from accepting the current beat.
    always_comb begin
        beat_ovf = ovf_q | add_cout;
        beat_cnt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef ACC_SATURATE_EN
        beat_acc = beat_ovf ? {ACC_W{1'b1}} : add_sum;
`else
        beat_acc = add_sum;
`endif
    end

    // Next-state and datapath update for the ACCUM/HOLD handshake FSM.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (in_last) begin
                        out_sum_d   = beat_acc;
                        out_count_d = beat_cnt;
                        out_ovf_d   = beat_ovf;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = beat_acc;
                        cnt_d = beat_cnt;
                        ovf_d = beat_ovf;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers; reset discards any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, matching flop behaviour.
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
